// File: rtl/regfile_port_ctrl_if.sv
// regfile_port_ctrl_if: CPU-side read-request, response and write channels of the register file controller
interface regfile_port_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_rs1;
  logic [ADDR_WIDTH-1:0] rd_rs2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rs1_data;
  logic [DATA_WIDTH-1:0] rsp_rs2_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  modport master (
    output rd_valid, rd_rs1, rd_rs2, rsp_ready, wr_valid, wr_addr, wr_data,
    input  rd_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, wr_ready
  );
  modport slave (
    input  rd_valid, rd_rs1, rd_rs2, rsp_ready, wr_valid, wr_addr, wr_data,
    output rd_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, wr_ready
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: clears the 32x32 RAM after reset, sequences two-operand reads over its one read port, forwards same-cycle writes
module regfile_port_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_port_ctrl_if.slave    bus,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic                  ram_we
);
  typedef enum logic [2:0] {CLEAR, IDLE, RD1, RD2, RSP} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, rs1, rs2;
  logic [DATA_WIDTH-1:0] d1, d2;
  logic wr_fire, hit1, hit2, clearing;
  assign clearing         = state == CLEAR;
  assign bus.wr_ready     = !clearing;
  assign bus.rd_ready     = state == IDLE;
  assign bus.rsp_valid    = state == RSP;
  assign bus.rsp_rs1_data = d1;
  assign bus.rsp_rs2_data = d2;
  assign wr_fire          = bus.wr_valid && !clearing;
  // x0 never forwards: a write to it is accepted but discarded
  assign hit1             = wr_fire && bus.wr_addr == rs1 && rs1 != '0;
  assign hit2             = wr_fire && bus.wr_addr == rs2 && rs2 != '0;
  assign ram_we           = !rst && (clearing || (wr_fire && bus.wr_addr != '0));
  assign ram_waddr        = clearing ? cnt : bus.wr_addr;
  assign ram_di           = clearing ? '0 : bus.wr_data;
  assign ram_raddr        = state == RD1 ? rs1 : state == RD2 ? rs2 : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else state <= IDLE;
      cnt       <= '0;
      rs1       <= '0;
      rs2       <= '0;
      d1        <= '0;
      d2        <= '0;
      init_done <= !CLEAR_ON_RESET;
    end else begin
      state <= state_nx;
      if (clearing) cnt <= cnt + 1'b1;
      if (clearing && &cnt) init_done <= 1'b1;
      if (state == IDLE && bus.rd_valid) begin
        rs1 <= bus.rd_rs1;
        rs2 <= bus.rd_rs2;
      end
      if (state == RD1) d1 <= rs1 == '0 ? '0 : hit1 ? bus.wr_data : ram_do;
      if (state == RD2) begin
        d2 <= rs2 == '0 ? '0 : hit2 ? bus.wr_data : ram_do;
        if (hit1) d1 <= bus.wr_data;
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   state_nx = &cnt ? IDLE : CLEAR;
      IDLE:    state_nx = bus.rd_valid ? RD1 : IDLE;
      RD1:     state_nx = RD2;
      RD2:     state_nx = RSP;
      RSP:     state_nx = bus.rsp_ready ? IDLE : RSP;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: scoreboard bench for the register file controller driving a behavioural 32x32 RAM
module tb_regfile_port_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_port_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  logic        init_done, ram_we;
  logic [4:0]  ram_raddr, ram_waddr;
  logic [31:0] ram_do, ram_di;
  logic [31:0] mem [32];
  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_di;
  assign ram_do = mem[ram_raddr];
  regfile_port_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_done(init_done),
    .ram_raddr(ram_raddr), .ram_do(ram_do), .ram_waddr(ram_waddr),
    .ram_di(ram_di), .ram_we(ram_we)
  );
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb [$];
  logic [31:0] ref_regs [32];

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({bus.rsp_valid, init_done, ram_we, bus.rd_ready, bus.wr_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000", {bus.rsp_valid, init_done, ram_we, bus.rd_ready, bus.wr_ready});
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      n_cmp++;
      if ({ram_we, ram_di, ram_waddr, bus.rd_ready, bus.wr_ready, init_done} !== {1'b1, 32'h0, i[4:0], 3'b000}) begin
        n_bad++;
        $display("FAIL clear_cycle_%0d: we=%b di=%h waddr=%0d rd_ready=%b wr_ready=%b init_done=%b want we=1 di=0 waddr=%0d others 0",
                 i, ram_we, ram_di, ram_waddr, bus.rd_ready, bus.wr_ready, init_done, i);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if ({init_done, bus.rd_ready, bus.wr_ready} !== 3'b111) begin
      n_bad++;
      $display("FAIL clear_done: init_done/rd_ready/wr_ready got %b want 111", {init_done, bus.rd_ready, bus.wr_ready});
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    @(negedge clk);
    n_cmp++;
    if ({bus.wr_ready, ram_we} !== {1'b1, a != 5'd0}) begin
      n_bad++;
      $display("FAIL write_x%0d: wr_ready/ram_we got %b want %b", a, {bus.wr_ready, ram_we}, {1'b1, a != 5'd0});
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    if (a != 5'd0) ref_regs[a] = d;
  endtask

  task automatic do_read(input logic [4:0] r1, input logic [4:0] r2,
                         input bit fwd, input logic [4:0] fa, input logic [31:0] fd,
                         input bit rsp_wr, input logic [4:0] wa, input logic [31:0] wd,
                         input int hold);
    logic [63:0] exp;
    int n;
    bit got;
    @(posedge clk); #1;
    bus.rd_valid = 1'b1;
    bus.rd_rs1   = r1;
    bus.rd_rs2   = r2;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL read_accept: rd_ready got %b want 1", bus.rd_ready);
    end
    if (fwd && fa != 5'd0) ref_regs[fa] = fd;
    sb.push_back({ref_regs[r1], ref_regs[r2]});
    got = 1'b0;
    for (n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      bus.rd_valid = 1'b0;
      bus.wr_valid = 1'b0;
      if (n == 1 && fwd) begin
        bus.wr_valid = 1'b1;
        bus.wr_addr  = fa;
        bus.wr_data  = fd;
      end
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!got || n != 3) begin
      n_bad++;
      $display("FAIL rsp_latency: rsp_valid after %0d cycles (seen=%b) want 3", n, got);
    end
    if (!got) begin
      void'(sb.pop_front());
      return;
    end
    if (rsp_wr) begin
      @(posedge clk); #1;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
      if (wa != 5'd0) ref_regs[wa] = wd;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.wr_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.rsp_valid, bus.rd_ready, bus.rsp_rs1_data, bus.rsp_rs2_data} !== {2'b10, sb[0]}) begin
        n_bad++;
        $display("FAIL hold_cycle_%0d: valid=%b rd_ready=%b data=%h_%h want valid=1 rd_ready=0 data=%h_%h",
                 h, bus.rsp_valid, bus.rd_ready, bus.rsp_rs1_data, bus.rsp_rs2_data, sb[0][63:32], sb[0][31:0]);
      end
    end
    @(posedge clk); #1;
    bus.wr_valid  = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    exp = sb.pop_front();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data} !== {1'b1, exp}) begin
      n_bad++;
      $display("FAIL read_x%0d_x%0d: valid=%b data=%h_%h want valid=1 data=%h_%h",
               r1, r2, bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data, exp[63:32], exp[31:0]);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.rsp_valid, bus.rd_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL back_to_idle: rsp_valid/rd_ready got %b want 01", {bus.rsp_valid, bus.rd_ready});
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
  endtask

  task automatic test_x0();
    do_write(5'd0, 32'h00001234);
    do_read(5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
  endtask

  task automatic test_forward();
    do_write(5'd7, 32'h1);
    do_read(5'd7, 5'd7, 1, 5'd7, 32'h2, 1, 5'd7, 32'h3, 0);
    do_read(5'd7, 5'd7, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    do_read(5'd5, 5'd7, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 0);
    do_read(5'd0, 5'd9, 1, 5'd0, 32'h55, 0, 5'd0, 32'h0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      do_write(5'($urandom_range(1, 31)), $urandom);
      do_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    end
  endtask

  task automatic test_hold();
    do_read(5'd5, 5'd7, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5);
  endtask

  task automatic test_reset_rsp();
    @(posedge clk); #1;
    bus.rd_valid = 1'b1;
    bus.rd_rs1   = 5'd5;
    bus.rd_rs2   = 5'd7;
    @(posedge clk); #1;
    bus.rd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_rsp: rsp_valid got %b want 1", bus.rsp_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.rsp_valid, init_done, ram_we, bus.rd_ready, bus.wr_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_in_rsp: got %b want 00000", {bus.rsp_valid, init_done, ram_we, bus.rd_ready, bus.wr_ready});
    end
    foreach (ref_regs[i]) ref_regs[i] = 32'h0;
    test_clear();
    do_read(5'd5, 5'd7, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    do_read(5'd9, 5'd31, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
  endtask

  initial begin
    bus.rd_valid  = 1'b0;
    bus.rd_rs1    = 5'd0;
    bus.rd_rs2    = 5'd0;
    bus.rsp_ready = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = 5'd0;
    bus.wr_data   = 32'h0;
    foreach (ref_regs[i]) ref_regs[i] = 32'h0;
    test_reset();
    test_clear();
    test_write_read();
    test_x0();
    test_forward();
    test_random();
    test_hold();
    test_reset_rsp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Access controller that drives the single-write, single-asynchronous-read 32x32 distributed-RAM register file on behalf of the CPU core. It zero-clears the RAM after reset. It serves two-operand read requests (rs1, rs2) by sequencing the one RAM read port over two cycles, and it accepts register writes concurrently. x0 is hard-wired to zero, and the returned snapshot includes same-cycle write forwarding.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width (32 entries)
- CLEAR_ON_RESET, 1, 1 = run 32-cycle zero-clear after reset; 0 = go straight to IDLE
- clk  in  1  system clock; also drives the RAM wclk at top level
- rst  in  1  asynchronous, active-high reset
- rd_valid  in  1  operand read request
- rd_ready  out  1  request accepted when rd_valid & rd_ready
- rd_rs1, rd_rs2  in  ADDR_WIDTH  operand indices
- rsp_valid  out  1  operand data valid
- rsp_ready  in  1  consumer takes response
- rsp_rs1_data, rsp_rs2_data  out  DATA_WIDTH  operand values
- wr_valid  in  1  register write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_WIDTH  destination index
- wr_data  in  DATA_WIDTH  write data
- init_done  out  1  clear complete; stays high until next reset
- ram_raddr  out  ADDR_WIDTH  to RAM raddr
- ram_do  in  DATA_WIDTH  from RAM do (combinational read)
- ram_waddr  out  ADDR_WIDTH  to RAM waddr
- ram_di  out  DATA_WIDTH  to RAM di
- ram_we  out  1  to RAM we

## Operation
- States: CLEAR, IDLE, RD1, RD2, RSP.
- Reset state: CLEAR if CLEAR_ON_RESET, else IDLE. Clear counter is 0.
- Reset values: rsp_valid 0, rsp data 0, latched rs1/rs2 0, init_done 0 (1 if CLEAR_ON_RESET=0). ram_we is forced 0 while rst is high.
- CLEAR:
  - ram_we=1, ram_waddr=counter, ram_di=0. Counter increments each cycle.
  - After writing entry 31, go to IDLE and set init_done=1.
  - rd_ready=0 and wr_ready=0.
- Write port:
  - wr_ready=1 in every state except CLEAR.
  - An accepted write drives ram_we=1, ram_waddr=wr_addr, ram_di=wr_data combinationally in the same cycle. The RAM commits it at the next clk edge.
  - A write with wr_addr=0 is accepted, but ram_we stays 0.
- IDLE: rd_ready=1. An accepted request latches rd_rs1 and rd_rs2, then goes to RD1.
- RD1:
  - ram_raddr = latched rs1. rs1_data is captured at the clock edge.
  - Captured value is 0 if rs1=0. If an accepted write targets rs1 in this cycle, wr_data is captured. Otherwise ram_do is captured.
  - Next state: RD2.
- RD2:
  - Same rule for rs2, with ram_raddr = latched rs2.
  - An accepted write this cycle to a nonzero address equal to latched rs1 also overwrites rs1_data.
  - Next state: RSP.
- Snapshot semantics: the response reflects all writes accepted up to and including the RD2 cycle.
- RSP:
  - rsp_valid=1. Data is held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE and clear rsp_valid.
  - Writes during RSP never alter the held data.
- ram_raddr is 0 outside RD1/RD2.
- Reset asserted in any state aborts immediately: pending response dropped, clear restarted.

## Timing
- Request accepted in cycle 0 → RD1 in cycle 1, RD2 in cycle 2, rsp_valid high from cycle 3.
- Minimum request spacing is 4 cycles: rsp_ready high in cycle 3 puts IDLE in cycle 4.
- Clear lasts exactly 32 cycles after rst deasserts. init_done is high from cycle 32; rd_ready and wr_ready are first high in that cycle.
- Write port has zero-cycle acceptance latency. The RAM contents update at the edge ending the accept cycle.

## Test plan
- Release reset with CLEAR_ON_RESET=1 → ram_we=1, ram_di=0, ram_waddr=0..31 over cycles 0..31. init_done=1 at cycle 32. rd_ready and wr_ready are 0 throughout the clear.
- Write x5=0xDEADBEEF, then read rs1=5, rs2=0 → rsp_valid rises 3 cycles after accept, with rs1_data=0xDEADBEEF and rs2_data=0x00000000.
- Write x0=0x00001234 → wr_ready=1 but ram_we=0. A subsequent read of rs1=0, rs2=0 returns 0 and 0.
- x7=1; read rs1=7, rs2=7 with a write x7=2 during RD1 → both operands return 0x2. A write x7=3 during RSP leaves the held data at 0x2, and the next read returns 0x3.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and both data words stay stable and rd_ready=0. rsp_ready=1 → IDLE the next cycle.
- Assert rst during RSP → rsp_valid=0 and init_done=0 immediately. After release, the 32-cycle clear repeats and previously written registers read 0.
